// File: rtl/i2s_pkg.sv
// Shared types and helpers for the I2S transmit controller.
package i2s_pkg;

  typedef enum logic {
    WAIT_RDY = 1'b0,
    HOLD     = 1'b1
  } arb_state_e;

  localparam int unsigned UNDERRUN_W = 8;

  // Minimum counter width able to hold 0..value-1 (never less than 1 bit).
  function automatic int unsigned clogb2(input int unsigned value);
    clogb2 = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) clogb2 = i + 1;
    end
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Codec bit-clock and left/right clock generator for the I2S transmitter.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned BCLK_DIV  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic cbclk,
  output logic cbrise,
  output logic cbfall,
  output logic clrclk
);

  localparam int unsigned HALF_BITS = DATA_BITS / 2;
  localparam int unsigned DIV_W     = clogb2(BCLK_DIV);
  localparam int unsigned BIT_W     = clogb2(HALF_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(HALF_BITS - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             cbclk_q, cbclk_d;
  logic             cbrise_q, cbrise_d;
  logic             cbfall_q, cbfall_d;
  logic             clrclk_q, clrclk_d;

  // Strobes are registered but computed from the next counter value, so each
  // strobe is high in the same cycle the counter holds the matching value.
  // A fall strobe only comes from a counter wrap, which also keeps it off the
  // first enabled cycle.
  always_comb begin
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    cbclk_d   = cbclk_q;
    cbrise_d  = 1'b0;
    cbfall_d  = 1'b0;
    clrclk_d  = clrclk_q;
    if (!en) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      cbclk_d   = 1'b0;
      clrclk_d  = 1'b0;
    end else begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
      cbrise_d  = (div_cnt_d == DIV_HALF);
      cbfall_d  = (div_cnt_q == DIV_LAST);
      if (cbrise_d) cbclk_d = 1'b1;
      if (cbfall_d) begin
        cbclk_d   = 1'b0;
        bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) clrclk_d = ~clrclk_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      cbclk_q   <= 1'b0;
      cbrise_q  <= 1'b0;
      cbfall_q  <= 1'b0;
      clrclk_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      cbclk_q   <= cbclk_d;
      cbrise_q  <= cbrise_d;
      cbfall_q  <= cbfall_d;
      clrclk_q  <= clrclk_d;
    end
  end

  assign cbclk  = cbclk_q;
  assign cbrise = cbrise_q;
  assign cbfall = cbfall_q;
  assign clrclk = clrclk_q;

endmodule

// File: rtl/i2s_xmit_ctrl.sv
// I2S transmit sequencer: clock generation, two-source sample arbitration and
// underrun accounting.
module i2s_xmit_ctrl
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned BCLK_DIV  = 4,
  parameter int          TPD       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mute,
  input  logic [DATA_BITS-1:0]  a_data,
  input  logic                  a_valid,
  output logic                  a_ack,
  input  logic [DATA_BITS-1:0]  b_data,
  input  logic                  b_valid,
  output logic                  b_ack,
  output logic                  cbclk,
  output logic                  cbrise,
  output logic                  cbfall,
  output logic                  clrclk,
  output logic [DATA_BITS-1:0]  sample,
  input  logic                  xmit_rdy,
  output logic                  xmit_ack,
  output logic [UNDERRUN_W-1:0] underrun_cnt,
  input  logic                  underrun_clr
);

  if ((DATA_BITS % 2) != 0 || DATA_BITS < 4 || (BCLK_DIV % 2) != 0 ||
      BCLK_DIV < 4 || TPD < 0) begin : g_param_check
    $error("i2s_xmit_ctrl: illegal parameter set");
  end

  i2s_clk_gen #(
    .DATA_BITS(DATA_BITS),
    .BCLK_DIV (BCLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .cbclk (cbclk),
    .cbrise(cbrise),
    .cbfall(cbfall),
    .clrclk(clrclk)
  );

  arb_state_e                state_q, state_d;
  logic [DATA_BITS-1:0]      sample_q, sample_d;
  logic                      xmit_ack_q, xmit_ack_d;
  logic                      a_ack_q, a_ack_d;
  logic                      b_ack_q, b_ack_d;
  logic [UNDERRUN_W-1:0]     underrun_cnt_q, underrun_cnt_d;
  logic [DATA_BITS-1:0]      pick;
  logic                      underrun;

  always_comb begin
    state_d        = state_q;
    sample_d       = sample_q;
    xmit_ack_d     = 1'b0;
    a_ack_d        = 1'b0;
    b_ack_d        = 1'b0;
    underrun_cnt_d = underrun_cnt_q;
    pick           = '0;
    underrun       = 1'b0;

    case (state_q)
      WAIT_RDY: begin
        if (xmit_rdy) begin
          if (a_valid) begin
            pick    = a_data;
            a_ack_d = 1'b1;
          end else if (b_valid) begin
            pick    = b_data;
            b_ack_d = 1'b1;
          end else begin
            underrun = 1'b1;
          end
          sample_d   = mute ? '0 : pick;
          xmit_ack_d = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (!xmit_rdy) state_d = WAIT_RDY;
      end
      default: state_d = WAIT_RDY;
    endcase

    // Clear wins, but an underrun in the same cycle is still counted.
    if (underrun_clr) begin
      underrun_cnt_d = underrun ? UNDERRUN_W'(1) : '0;
    end else if (underrun && underrun_cnt_q != '1) begin
      underrun_cnt_d = underrun_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_RDY;
      sample_q       <= '0;
      xmit_ack_q     <= 1'b0;
      a_ack_q        <= 1'b0;
      b_ack_q        <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      sample_q       <= sample_d;
      xmit_ack_q     <= xmit_ack_d;
      a_ack_q        <= a_ack_d;
      b_ack_q        <= b_ack_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign sample       = sample_q;
  assign xmit_ack     = xmit_ack_q;
  assign a_ack        = a_ack_q;
  assign b_ack        = b_ack_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: doc/i2s_xmit_ctrl.md
Name: i2s_xmit_ctrl

Overview:
Sequencing controller for the I2S transmit datapath.
- Generates the codec bit-clock enables (CBrise/CBfall strobes), the CBCLK level and the left/right clock from the system clock.
- Arbitrates two sample sources (A = priority, B = secondary) onto the transmitter's single sample/xmit_rdy/xmit_ack handshake.
- Inserts zero samples and counts underruns when neither source has data.

Parameters:
DATA_BITS, 32, total bits per stereo frame (left+right); even, >=4
BCLK_DIV, 4, clk cycles per CBCLK period; even, >=4
TPD, 5, simulation-only register delay

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  run enable for clock generation
mute  in  1  force zero samples; sources still consumed
a_data  in  DATA_BITS  source A sample {left,right}
a_valid  in  1  source A has a sample
a_ack  out  1  one-cycle pulse: A sample taken
b_data  in  DATA_BITS  source B sample
b_valid  in  1  source B has a sample
b_ack  out  1  one-cycle pulse: B sample taken
cbclk  out  1  CBCLK level
cbrise  out  1  one-cycle strobe, CBCLK rising
cbfall  out  1  one-cycle strobe, CBCLK falling
clrclk  out  1  left/right clock
sample  out  DATA_BITS  held sample to transmitter
xmit_rdy  in  1  transmitter ready
xmit_ack  out  1  one-cycle pulse to transmitter
underrun_cnt  out  8  saturating underrun count
underrun_clr  in  1  clear underrun_cnt

Behaviour:
Reset values: all outputs 0; div_cnt=0; bit_cnt=0; arbiter state WAIT_RDY.

Clock generation (div_cnt 0..BCLK_DIV-1, bit_cnt 0..DATA_BITS/2-1):
- When en=1, div_cnt increments every cycle and wraps to 0.
- cbrise=1 in the cycle div_cnt==BCLK_DIV/2.
- cbfall=1 in the cycle div_cnt==0, except the first cycle after en rises.
- cbclk is registered: set with cbrise, cleared with cbfall.
- On each cbfall, bit_cnt increments. On wrap DATA_BITS/2-1 -> 0, clrclk toggles in the same cycle.
- Result: clrclk period = DATA_BITS CBCLK periods; clrclk changes only coincident with cbfall.
- en=0: next cycle div_cnt, bit_cnt, cbclk and clrclk go to 0 and no strobes are issued. Re-enabling starts a fresh frame with clrclk low.
- en does not affect the arbiter.

Arbiter FSM:
- WAIT_RDY, on xmit_rdy=1:
  - If a_valid: select a_data and pulse a_ack.
  - Else if b_valid: select b_data and pulse b_ack.
  - Else (underrun): select 0 and increment underrun_cnt.
  - In every case: load sample (0 if mute=1), pulse xmit_ack in that same cycle, go to HOLD.
- HOLD: sample held stable. When xmit_rdy=0 (transmitter has left idle), go to WAIT_RDY.
- Decision latency: one clk from xmit_rdy rising to sample/xmit_ack valid.
- At most one of a_ack/b_ack per frame; never both.
- If xmit_rdy is already 1 when leaving reset, the first decision occurs on the first cycle after rst deasserts.

Counter rules:
- underrun_cnt saturates at 255.
- underrun_clr has priority. Clear and underrun in the same cycle gives underrun_cnt=1.

Mute: sources are still acked and consumed; only the data is zeroed. No underrun is counted when a source was valid.

Reset mid-operation: all state returns to reset values next cycle. Pending acks are dropped; no partial pulses.

Decomposition:
- Shared package i2s_pkg: arbiter state encodings (WAIT_RDY, HOLD) and a clogb2 function for counter widths.
- One natural sub-module: i2s_clk_gen (div_cnt, bit_cnt, cbclk, cbrise, cbfall, clrclk). Arbiter and underrun counter stay in the top.

Test Plan:
- Clock generation: rst then en=1, BCLK_DIV=4, DATA_BITS=32 -> cbrise every 4 clks at div_cnt 2; cbclk 50% duty; clrclk toggles every 16 cbfall, period 128 clks.
- A priority: a_valid=b_valid=1, a_data=0x12345678, xmit_rdy pulse -> one clk later sample=0x12345678, xmit_ack=1, a_ack=1, b_ack=0; sample unchanged until xmit_rdy falls.
- Underrun: no source valid for 3 xmit_rdy events -> sample=0, underrun_cnt=3. Repeat 300 times -> 255.
- Clear collision: underrun_clr coincident with an underrun -> underrun_cnt=1.
- Mute: mute=1, b_valid=1, b_data=0xFFFF0001 -> sample=0, b_ack=1, underrun_cnt unchanged.
- Disable and reset mid-frame: en=0 mid-frame -> strobes stop, clrclk=0 next cycle; en=1 -> first cbfall BCLK_DIV clks later. rst during HOLD -> sample=0, state WAIT_RDY.
